d_fd_reg: RTL
=============

# d_fd_reg

F/D pipeline register of the 5-stage MIPS core with precise-exception support. It captures the PC and instruction produced by the fetch stage, converts a fetch address error into an exception code, and tags branch-delay-slot instructions. It supports stall (hold), exception flush (bubble at the handler address) and reset. It also keeps a free-running count of instructions accepted into D.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, value of D_pc after reset
- HANDLER_PC, 32'h0000_4180, value of D_pc when a bubble is inserted by an exception flush
- EXC_ADEL, 5'd4, exception code for an instruction-fetch address error

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- en  in  1  advance enable (= !stall from hazard unit)
- req  in  1  exception/interrupt taken this cycle; flushes the register
- F_pc  in  32  PC of the instruction currently in F (already eret-muxed)
- F_instr  in  32  instruction word read from IM at F_pc
- F_adel  in  1  fetch address error for F_pc
- D_is_bj  in  1  instruction currently held in D is a branch or jump (from D decoder)
- D_pc  out  32  PC of the instruction in D
- D_instr  out  32  instruction in D
- D_exccode  out  5  exception code carried with D instruction (0 = none)
- D_bd  out  1  instruction in D sits in a branch delay slot
- D_valid  out  1  D holds a real fetched instruction (0 = bubble)
- fetch_cnt  out  32  number of instructions accepted into D since reset

## Operation
- Priority per cycle: reset > req > en > hold.
- reset: D_pc=RESET_PC, D_instr=0, D_exccode=0, D_bd=0, D_valid=0, fetch_cnt=0.
- req (en ignored): D_pc=HANDLER_PC, D_instr=0 (nop), D_exccode=0, D_bd=0, D_valid=0; fetch_cnt unchanged.
- en, no req: D_pc=F_pc, D_valid=1, D_bd=D_is_bj (sampled from the outgoing D instruction), fetch_cnt+1.
  - F_adel=1: D_instr=0, D_exccode=EXC_ADEL.
  - F_adel=0: D_instr=F_instr, D_exccode=0.
- en=0, no req: every output holds, including D_bd; D_is_bj is ignored while stalled.
- fetch_cnt: 32-bit unsigned; wraps 32'hFFFF_FFFF -> 0. Counts faulting (F_adel) fetches because they are accepted into D.
- D_pc is always the faulting PC, never zeroed, so the EPC logic downstream reads it. D_bd lets the EPC logic use D_pc-4.

## Timing
- Latency is 1 cycle: F inputs present in cycle n appear on the D_* outputs after posedge n+1.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset asserted mid-stream takes effect at the next posedge regardless of en/req. Outputs hold their reset values while reset stays high.
- req and en=0 in the same cycle: flush wins and the bubble is inserted; fetch_cnt does not increment.
- Back-to-back req: D_pc stays HANDLER_PC and D_valid stays 0.
- A bubble in D has D_is_bj=0 by construction, so the first instruction after a flush gets D_bd=0.

## Test plan
- Reset: hold reset 2 cycles with F_pc=0x3010, en=1 -> D_pc=0x3000, D_instr=0, D_valid=0, fetch_cnt=0.
- Normal advance: en=1, F_pc=0x3000/0x3004, F_instr=0x3C010001/0x34210002 on successive cycles -> D follows one cycle later, D_exccode=0, fetch_cnt=2.
- Stall: en=0 for 3 cycles while F_pc changes -> D_pc, D_instr, D_bd and fetch_cnt frozen; release gives the new F_pc after one cycle.
- Delay slot: D holds beq (D_is_bj=1), en=1, F_pc=0x3008 -> D_pc=0x3008, D_bd=1. The next advance with D_is_bj=0 gives D_bd=0.
- AdEL: F_pc=0x3002, F_adel=1, F_instr=0xFFFFFFFF -> D_instr=0, D_exccode=4, D_pc=0x3002, D_valid=1.
- Flush priority: req=1 with en=0, then req=1 with en=1 -> D_pc=0x4180, D_instr=0, D_valid=0, D_bd=0, fetch_cnt unchanged. Preload fetch_cnt=0xFFFFFFFF and advance once -> 0.

Source files
------------

// File: rtl/d_fd_reg.sv
// F/D pipeline register of the 5-stage MIPS core. It captures the fetch PC and
// instruction, converts fetch address errors to AdEL, tags delay slots and counts accepted fetches.
module d_fd_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req,
  input  logic [31:0] F_pc,
  input  logic [31:0] F_instr,
  input  logic        F_adel,
  input  logic        D_is_bj,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [4:0]  D_exccode,
  output logic        D_bd,
  output logic        D_valid,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        bd_q, bd_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  // Next-state selection: flush beats advance, advance beats hold.
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    exccode_d   = exccode_q;
    bd_d        = bd_q;
    valid_d     = valid_q;
    fetch_cnt_d = fetch_cnt_q;
    if (req) begin
      pc_d      = HANDLER_PC;
      instr_d   = 32'h0000_0000;
      exccode_d = 5'd0;
      bd_d      = 1'b0;
      valid_d   = 1'b0;
    end else if (en) begin
      // A faulting fetch keeps its PC for EPC but carries a nop instead of the word.
      pc_d        = F_pc;
      valid_d     = 1'b1;
      bd_d        = D_is_bj;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (F_adel) begin
        instr_d   = 32'h0000_0000;
        exccode_d = EXC_ADEL;
      end else begin
        instr_d   = F_instr;
        exccode_d = 5'd0;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= 32'h0000_0000;
      exccode_q   <= 5'd0;
      bd_q        <= 1'b0;
      valid_q     <= 1'b0;
      fetch_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      exccode_q   <= exccode_d;
      bd_q        <= bd_d;
      valid_q     <= valid_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign D_pc      = pc_q;
  assign D_instr   = instr_q;
  assign D_exccode = exccode_q;
  assign D_bd      = bd_q;
  assign D_valid   = valid_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule
